trng_sample_controller: RTL and testbench

- Sequences the TRNG entropy path. Enables the raw entropy source and discards bits during a warm-up window.
- Packs debiased bits (from the von Neumann stage's out_bit/valid) into WORD_W-bit words and presents them on a valid/ready interface.
- Runs a repetition-count health test and a starvation timeout on the debiased stream; a sticky fault shuts the source down.

---
 rtl/trng_sample_controller.sv | 216 +++++++++++++++++++++
 tb/tb_trng_sample_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_sample_controller.sv
// -----------------------------------------------------------------------------
// trng_sample_controller
//
// Sequences the TRNG entropy path:
//   - powers the ring-oscillator source and discards its output for a warm-up
//     window,
//   - packs debiased bits MSB-first into WORD_W-bit words and offers each word
//     on a valid/ready interface,
//   - runs a repetition-count health test and a starvation timeout on the
//     debiased stream. Either failure is sticky, shuts the source down, and
//     is cleared only by clear_fail.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        begin generation (honoured only in IDLE, ignored if stop is high)
//   stop         end generation (deferred until handshake while a word is held)
//   clear_fail   clear the sticky fault (honoured only in FAIL)
//   src_en       enable to the entropy source
//   deb_bit      debiased bit
//   deb_valid    qualifies deb_bit for one cycle
//   word_out     assembled random word
//   word_valid   word_out is valid
//   rd_ready     consumer accepts the word
//   busy         high in WARMUP, COLLECT and HOLD
//   health_fail  sticky fault flag
//   word_cnt     count of delivered words, wraps at 65535 -> 0
// -----------------------------------------------------------------------------
module trng_sample_controller #(
   parameter int WORD_W         = 32,
   parameter int WARMUP_CYCLES  = 256,
   parameter int REP_LIMIT      = 32,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              clear_fail,
   output logic              src_en,
   input  logic              deb_bit,
   input  logic              deb_valid,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   input  logic              rd_ready,
   output logic              busy,
   output logic              health_fail,
   output logic [15:0]       word_cnt
);

   localparam int BIT_W  = $clog2(WORD_W + 1);
   localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
   localparam int REP_W  = $clog2(REP_LIMIT + 1);
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
   localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
   localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REP_LIMIT);
   localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WARMUP  = 3'd1,
      ST_COLLECT = 3'd2,
      ST_HOLD    = 3'd3,
      ST_FAIL    = 3'd4
   } state_t;

   state_t              state_r;
   logic [WARM_W-1:0]   warm_cnt_r;
   logic [BIT_W-1:0]    bit_cnt_r;
   logic [REP_W-1:0]    rep_cnt_r;
   logic [TO_W-1:0]     to_cnt_r;
   // Only WORD_W-1 bits are stored: the final bit of a word comes straight
   // from deb_bit when the word is completed.
   logic [WORD_W-2:0]   shreg_r;
   logic                prev_bit_r;
   logic                stop_pend_r;

   logic [REP_W-1:0]    rep_next_s;
   logic [TO_W-1:0]     to_next_s;
   logic                rep_hit_s;
   logic                to_hit_s;
   logic                word_done_s;
   logic [WORD_W-1:0]   shift_s;

   // Next-value and limit detection for the health test, timeout and packer.
   always_comb begin
      rep_next_s  = REP_W'(1);
      // rep_cnt_r == 0 means no bit accepted yet in this run: the first bit
      // always starts a new run of length 1.
      if ((rep_cnt_r != {REP_W{1'b0}}) && (deb_bit == prev_bit_r)) begin
         rep_next_s = rep_cnt_r + REP_W'(1);
      end else begin
         rep_next_s = REP_W'(1);
      end
      to_next_s   = to_cnt_r + TO_W'(1);
      rep_hit_s   = (rep_next_s == REP_MAX);
      to_hit_s    = (to_next_s == TO_MAX);
      word_done_s = (bit_cnt_r == BIT_LAST);
      shift_s     = {shreg_r, deb_bit};
   end

   // Main controller FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         src_en      <= 1'b0;
         word_out    <= {WORD_W{1'b0}};
         word_valid  <= 1'b0;
         busy        <= 1'b0;
         health_fail <= 1'b0;
         word_cnt    <= 16'd0;
         warm_cnt_r  <= {WARM_W{1'b0}};
         bit_cnt_r   <= {BIT_W{1'b0}};
         rep_cnt_r   <= {REP_W{1'b0}};
         to_cnt_r    <= {TO_W{1'b0}};
         shreg_r     <= {(WORD_W-1){1'b0}};
         prev_bit_r  <= 1'b0;
         stop_pend_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start && !stop) begin
                  state_r     <= ST_WARMUP;
                  src_en      <= 1'b1;
                  busy        <= 1'b1;
                  warm_cnt_r  <= {WARM_W{1'b0}};
                  bit_cnt_r   <= {BIT_W{1'b0}};
                  rep_cnt_r   <= {REP_W{1'b0}};
                  to_cnt_r    <= {TO_W{1'b0}};
                  shreg_r     <= {(WORD_W-1){1'b0}};
                  prev_bit_r  <= 1'b0;
                  stop_pend_r <= 1'b0;
               end
            end

            ST_WARMUP: begin
               if (stop) begin
                  state_r <= ST_IDLE;
                  src_en  <= 1'b0;
                  busy    <= 1'b0;
               end else if (warm_cnt_r == WARM_LAST) begin
                  state_r <= ST_COLLECT;
               end else begin
                  warm_cnt_r <= warm_cnt_r + WARM_W'(1);
               end
            end

            ST_COLLECT: begin
               // Failure outranks stop, which outranks normal packing.
               if ((deb_valid && rep_hit_s) || (!deb_valid && to_hit_s)) begin
                  state_r     <= ST_FAIL;
                  src_en      <= 1'b0;
                  busy        <= 1'b0;
                  word_valid  <= 1'b0;
                  health_fail <= 1'b1;
               end else if (stop) begin
                  state_r <= ST_IDLE;
                  src_en  <= 1'b0;
                  busy    <= 1'b0;
               end else if (deb_valid) begin
                  shreg_r    <= shift_s[WORD_W-2:0];
                  rep_cnt_r  <= rep_next_s;
                  prev_bit_r <= deb_bit;
                  to_cnt_r   <= {TO_W{1'b0}};
                  if (word_done_s) begin
                     word_out   <= shift_s;
                     word_valid <= 1'b1;
                     bit_cnt_r  <= {BIT_W{1'b0}};
                     state_r    <= ST_HOLD;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                  end
               end else begin
                  to_cnt_r <= to_next_s;
               end
            end

            ST_HOLD: begin
               // word_valid is always high here, so rd_ready alone completes
               // the handshake. A stop in the handshake cycle is honoured too.
               if (rd_ready) begin
                  word_valid  <= 1'b0;
                  word_cnt    <= word_cnt + 16'd1;
                  stop_pend_r <= 1'b0;
                  if (stop_pend_r || stop) begin
                     state_r <= ST_IDLE;
                     src_en  <= 1'b0;
                     busy    <= 1'b0;
                  end else begin
                     state_r <= ST_COLLECT;
                  end
               end else if (stop) begin
                  stop_pend_r <= 1'b1;
               end
            end

            ST_FAIL: begin
               if (clear_fail) begin
                  state_r     <= ST_IDLE;
                  health_fail <= 1'b0;
               end
            end

            default: begin
               state_r    <= ST_IDLE;
               src_en     <= 1'b0;
               busy       <= 1'b0;
               word_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trng_sample_controller.sv
// -----------------------------------------------------------------------------
// Testbench for trng_sample_controller (WORD_W=8, WARMUP_CYCLES=4,
// REP_LIMIT=4, TIMEOUT_CYCLES=16). Expected words are queued when their bits
// are issued; a monitor pops one at each rising word_valid and checks word_out
// for as long as the word is held. Status outputs are checked directly.
// -----------------------------------------------------------------------------
module tb_trng_sample_controller;

   localparam int WORD_W         = 8;
   localparam int WARMUP_CYCLES  = 4;
   localparam int REP_LIMIT      = 4;
   localparam int TIMEOUT_CYCLES = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        clear_fail = 1'b0;
   logic        deb_bit = 1'b0;
   logic        deb_valid = 1'b0;
   logic        rd_ready = 1'b0;
   logic        src_en;
   logic [7:0]  word_out;
   logic        word_valid;
   logic        busy;
   logic        health_fail;
   logic [15:0] word_cnt;

   int checks = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   trng_sample_controller #(
      .WORD_W(WORD_W),
      .WARMUP_CYCLES(WARMUP_CYCLES),
      .REP_LIMIT(REP_LIMIT),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .stop(stop),
      .clear_fail(clear_fail),
      .src_en(src_en),
      .deb_bit(deb_bit),
      .deb_valid(deb_valid),
      .word_out(word_out),
      .word_valid(word_valid),
      .rd_ready(rd_ready),
      .busy(busy),
      .health_fail(health_fail),
      .word_cnt(word_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Feed n bits from bits[n-1] down to bits[0] on consecutive cycles.
   task automatic send_bits(input logic [7:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         deb_valid = 1'b1;
         deb_bit   = bits[i];
         step();
      end
      deb_valid = 1'b0;
      deb_bit   = 1'b0;
   endtask

   // Start pulse plus the full warm-up; returns with the DUT in COLLECT.
   task automatic start_run();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (WARMUP_CYCLES) step();
   endtask

   task automatic deliver();
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
   endtask

   task automatic do_clear();
      clear_fail = 1'b1;
      step();
      clear_fail = 1'b0;
   endtask

   // Scoreboard monitor.
   initial begin
      logic [7:0] cur_exp;
      logic       prev_wv;
      logic       have_exp;
      cur_exp  = 8'h00;
      prev_wv  = 1'b0;
      have_exp = 1'b0;
      forever begin
         @(negedge clk);
         if (word_valid === 1'b1 && prev_wv === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               have_exp = 1'b0;
               $display("FAIL unexpected_word actual=%0h expected=none", word_out);
            end else begin
               cur_exp  = exp_q.pop_front();
               have_exp = 1'b1;
            end
         end
         if (word_valid === 1'b1 && have_exp) begin
            checks++;
            if (word_out !== cur_exp) begin
               failures++;
               $display("FAIL word_out actual=%0h expected=%0h", word_out, cur_exp);
            end
         end
         prev_wv = word_valid;
      end
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // Directed stimulus.
   initial begin
      repeat (2) step();
      chk("rst_src_en", 32'(src_en), 32'd0);
      chk("rst_word_out", 32'(word_out), 32'd0);
      chk("rst_word_valid", 32'(word_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_health_fail", 32'(health_fail), 32'd0);
      chk("rst_word_cnt", 32'(word_cnt), 32'd0);
      rst_n = 1'b1;
      step();

      // First word, with deb_valid pulses during warm-up that must be ignored.
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_src_en", 32'(src_en), 32'd1);
      chk("start_busy", 32'(busy), 32'd1);
      deb_valid = 1'b1;
      deb_bit   = 1'b1;
      repeat (WARMUP_CYCLES) step();
      deb_valid = 1'b0;
      exp_q.push_back(8'hB2);
      send_bits(8'h59, 7);
      chk("w1_not_yet_valid", 32'(word_valid), 32'd0);
      send_bits(8'h00, 1);
      chk("w1_valid", 32'(word_valid), 32'd1);
      chk("w1_word", 32'(word_out), 32'hB2);
      chk("w1_busy", 32'(busy), 32'd1);

      // Held word: extra bits (which would also trip the run test) are dropped.
      send_bits(8'h00, 3);
      repeat (2) step();
      chk("hold_valid", 32'(word_valid), 32'd1);
      chk("hold_word", 32'(word_out), 32'hB2);
      deliver();
      chk("hs1_valid", 32'(word_valid), 32'd0);
      chk("hs1_cnt", 32'(word_cnt), 32'd1);
      chk("hs1_busy", 32'(busy), 32'd1);

      exp_q.push_back(8'h69);
      send_bits(8'h69, 8);
      deliver();
      chk("hs2_cnt", 32'(word_cnt), 32'd2);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_src_en", 32'(src_en), 32'd0);

      // Repetition failure: four ones.
      start_run();
      send_bits(8'h0F, 4);
      chk("rep_fail_flag", 32'(health_fail), 32'd1);
      chk("rep_fail_src_en", 32'(src_en), 32'd0);
      chk("rep_fail_valid", 32'(word_valid), 32'd0);
      chk("rep_fail_busy", 32'(busy), 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("fail_start_ignored", 32'(src_en), 32'd0);
      chk("fail_sticky", 32'(health_fail), 32'd1);
      do_clear();
      chk("clear_flag", 32'(health_fail), 32'd0);
      chk("clear_busy", 32'(busy), 32'd0);
      chk("clear_cnt_kept", 32'(word_cnt), 32'd2);

      // Runs of three restart on each change; then a run across a word boundary.
      start_run();
      exp_q.push_back(8'h11);
      send_bits(8'h11, 8);
      chk("run3_no_fail", 32'(health_fail), 32'd0);
      deliver();
      chk("hs3_cnt", 32'(word_cnt), 32'd3);
      exp_q.push_back(8'h13);
      send_bits(8'h13, 8);
      deliver();
      chk("hs4_cnt", 32'(word_cnt), 32'd4);
      send_bits(8'h03, 2);
      chk("boundary_fail", 32'(health_fail), 32'd1);
      chk("boundary_no_word", 32'(word_valid), 32'd0);
      do_clear();

      // Starvation timeout.
      start_run();
      repeat (TIMEOUT_CYCLES - 1) step();
      chk("timeout_early", 32'(health_fail), 32'd0);
      step();
      chk("timeout_fail", 32'(health_fail), 32'd1);
      do_clear();

      // Stop mid-word: partial word is discarded.
      start_run();
      send_bits(8'h05, 3);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("midstop_busy", 32'(busy), 32'd0);
      chk("midstop_src_en", 32'(src_en), 32'd0);
      chk("midstop_valid", 32'(word_valid), 32'd0);
      start_run();
      exp_q.push_back(8'hCC);
      send_bits(8'hCC, 8);
      deliver();
      chk("hs5_cnt", 32'(word_cnt), 32'd5);

      // Stop in HOLD: word still delivered, then IDLE.
      exp_q.push_back(8'hA5);
      send_bits(8'hA5, 8);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("holdstop_valid", 32'(word_valid), 32'd1);
      chk("holdstop_busy", 32'(busy), 32'd1);
      deliver();
      chk("holdstop_hs_valid", 32'(word_valid), 32'd0);
      chk("holdstop_idle_busy", 32'(busy), 32'd0);
      chk("holdstop_src_en", 32'(src_en), 32'd0);
      chk("hs6_cnt", 32'(word_cnt), 32'd6);

      // Asynchronous reset while a word is held.
      start_run();
      exp_q.push_back(8'h5A);
      send_bits(8'h5A, 8);
      chk("pre_rst_valid", 32'(word_valid), 32'd1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(word_valid), 32'd0);
      chk("arst_src_en", 32'(src_en), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_cnt", 32'(word_cnt), 32'd0);
      step();
      rst_n = 1'b1;
      repeat (2) step();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
